my_mul_scale_ci: RTL
====================

// Module: my_mul_scale_ci
// PURPOSE
// - Parametrised multi-cycle Nios II custom instruction: unsigned multiply, constant-reciprocal scaling
//   (x*K>>SH), raw product words and a saturating accumulator, selected per call by n.
// - Sits on the CPU custom-instruction port (clk_en/start/done); system regen required after port edits.
// PARAMETERS
// - DW        32    operand/result width
// - KW        11    width of scale constant
// - SCALE_K   1311  scale multiplier (1311/2^19 ~= 1/400)
// - SCALE_SH  19    scale right-shift; must be >= 1
// PORTS
// - clk      in   1   single clock, all state on rising edge
// - reset    in   1   asynchronous, active-high
// - clk_en   in   1   stage-advance enable; low = full stall
// - start    in   1   call request, sampled in IDLE with clk_en=1
// - dataa    in   DW  operand A (unsigned)
// - datab    in   DW  operand B (unsigned)
// - n        in   3   op select: 0 SCALE, 1 MUL_LO, 2 MUL_HI, 3 MAC, 4 ACC_CLR, 5-7 reserved
// - done     out  1   one-cycle (clk_en-qualified) completion strobe
// - result   out  DW  registered result, valid while done=1, held until next done
// BEHAVIOUR
// - Reset: state=IDLE, done=0, result=0, acc=0, all pipeline regs 0; applies immediately, incl. mid-call.
// - FSM IDLE->MUL->SCL->FIN->IDLE; moves only on edges with clk_en=1; clk_en=0 freezes everything
//   (done/result held).
// - IDLE: start=1 -> capture dataa, datab, n; go MUL. start=0 -> stay, done=0.
// - MUL:  p <= A*B (2*DW bits, full precision).
// - SCL:  s <= (p*SCALE_K) >> SCALE_SH, full 2*DW+KW-bit intermediate, no truncation before shift.
// - FIN:  result/acc update per op; done=1 for this one enabled cycle; back to IDLE.
// - Latency: start edge T -> done=1 after edge T+3 (3 enabled cycles); clk_en low cycles add 1:1.
// - start while not IDLE ignored, no queueing; start with done=1 accepted (back-to-back every 4 cycles).
// - Op results at FIN:
//   SCALE  : result = s >= 2^DW ? {DW{1}} : s[DW-1:0]
//   MUL_LO : result = p[DW-1:0];  MUL_HI: result = p[2*DW-1:DW]
//   MAC    : acc = sat(acc + sat(s)); result = new acc; saturates at {DW{1}}, never wraps
//   ACC_CLR: result = old acc; acc = 0
//   5-7    : result = 0, acc unchanged, done still pulses
// - acc changes only at FIN of MAC/ACC_CLR; reset mid-call aborts with no acc update.
// - Operand/n changes after capture have no effect on the call in flight.
// CONFIGURATION
// - MY_MULSCALE_ROUND_EN defined: SCL adds 2^(SCALE_SH-1) before the shift (round half up); also for MAC.
// - Undefined: truncation (floor). Latency and ports identical in both builds.
// TESTING
// - Reset mid-call (T+2): done=0, result=0, next start completes in 3 cycles; a MAC call aborted by
//   reset leaves acc=0.
// - SCALE a=20000,b=400 -> 20004 after 3 cycles (both builds).
// - SCALE a=200,b=1 -> 0 without ROUND_EN, 1 with ROUND_EN.
// - MUL_LO/MUL_HI a=b=32'hFFFFFFFF -> 32'h00000001 / 32'hFFFFFFFE.
// - SCALE a=b=32'hFFFFFFFF -> 32'hFFFFFFFF (saturate).
// - ACC_CLR, MAC(20000,400) x2 -> 20004 then 40008; ACC_CLR -> 40008; next MAC from 0.
// - clk_en=0 for 2 cycles at T+1: done at T+5, result correct.
//   start pulses at T+1/T+2 ignored.
//   n=6 -> result 0, done pulses.

Source files
------------

// File: rtl/my_mul_scale_ci.sv
// Multi-cycle custom instruction: unsigned multiply, constant-reciprocal scaling, raw product words
// and a saturating accumulator. Define MY_MULSCALE_ROUND_EN to round the scaling step half-up.
module my_mul_scale_ci #(
    parameter int DW       = 32,
    parameter int KW       = 11,
    parameter int SCALE_K  = 1311,
    parameter int SCALE_SH = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          start,
    input  logic [DW-1:0] dataa,
    input  logic [DW-1:0] datab,
    input  logic [2:0]    n,
    output logic          done,
    output logic [DW-1:0] result
);

    localparam int PW = 2 * DW;
    // One spare bit so the rounding constant can never carry out of the intermediate.
    localparam int XW = 2 * DW + KW + 1;

`ifdef MY_MULSCALE_ROUND_EN
    localparam logic [XW-1:0] ROUND_ADD = XW'(1) << (SCALE_SH - 1);
`else
    localparam logic [XW-1:0] ROUND_ADD = '0;
`endif

    localparam logic [2:0] OP_SCALE   = 3'd0;
    localparam logic [2:0] OP_MUL_LO  = 3'd1;
    localparam logic [2:0] OP_MUL_HI  = 3'd2;
    localparam logic [2:0] OP_MAC     = 3'd3;
    localparam logic [2:0] OP_ACC_CLR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SCL  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic [PW-1:0] p_q, p_d;
    logic [XW-1:0] s_q, s_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] result_q, result_d;
    logic          done_q, done_d;

    logic [DW-1:0] s_sat;
    logic [DW:0]   acc_sum;

    assign s_sat   = (|s_q[XW-1:DW]) ? '1 : s_q[DW-1:0];
    assign acc_sum = {1'b0, acc_q} + {1'b0, s_sat};

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        p_d      = p_q;
        s_d      = s_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;

        if (clk_en) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d     = dataa;
                        b_d     = datab;
                        op_d    = n;
                        state_d = S_MUL;
                    end
                end
                S_MUL: begin
                    p_d     = PW'(a_q) * PW'(b_q);
                    state_d = S_SCL;
                end
                S_SCL: begin
                    s_d     = (XW'(p_q) * XW'(SCALE_K) + ROUND_ADD) >> SCALE_SH;
                    state_d = S_FIN;
                end
                S_FIN: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    case (op_q)
                        OP_SCALE:   result_d = s_sat;
                        OP_MUL_LO:  result_d = p_q[DW-1:0];
                        OP_MUL_HI:  result_d = p_q[PW-1:DW];
                        OP_MAC: begin
                            acc_d    = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
                            result_d = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
                        end
                        OP_ACC_CLR: begin
                            result_d = acc_q;
                            acc_d    = '0;
                        end
                        default:    result_d = '0;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            p_q      <= '0;
            s_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            p_q      <= p_d;
            s_q      <= s_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
